// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path.
package btb_pkg;

  localparam logic [1:0] BTB_DIRECT   = 2'b00;
  localparam logic [1:0] BTB_CALL     = 2'b01;
  localparam logic [1:0] BTB_RETURN   = 2'b10;
  localparam logic [1:0] BTB_INDIRECT = 2'b11;

  localparam int BTB_IDX_W = 6;

  // One pending BTB write: branch PC, resolved target and branch type.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] bta;
    logic [1:0]  btype;
  } btb_upd_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_INV = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Dual-push, single-pop FIFO of pending BTB updates. push0 is placed ahead
// of push1; flush empties the queue and dominates any push or pop.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push0,
  input  btb_upd_t               push0_data,
  input  logic                   push1,
  input  btb_upd_t               push1_data,
  input  logic                   pop,
  output btb_upd_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  btb_upd_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr1;

  // Slot 1 lands behind slot 0 when both push, otherwise at the write pointer.
  assign wr_ptr1 = wr_ptr + AW'(push0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; count moves by the net push/pop amount.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= push0_data;
    if (push1) mem[wr_ptr1] <= push1_data;
  end

endmodule

// File: rtl/btb_update_scheduler.sv
// Collects resolved branches from two commit slots, filters and merges them,
// queues them and drains one per cycle into the single-port BTB write port,
// yielding briefly to fetch lookups of the same set. Also sequences a full
// BTB invalidate walk on request.
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int IDX_W    = BTB_IDX_W,
  parameter int HOLD_MAX = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in0_valid,
  input  logic [31:0]      in0_pc,
  input  logic [31:0]      in0_target,
  input  logic [1:0]       in0_type,
  input  logic             in0_taken,
  input  logic             in1_valid,
  input  logic [31:0]      in1_pc,
  input  logic [31:0]      in1_target,
  input  logic [1:0]       in1_type,
  input  logic             in1_taken,
  output logic             in_ready,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic             inv_req,
  output logic             inv_busy,
  output logic             upd_en,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_bta,
  output logic [1:0]       upd_type,
  output logic             inv_en,
  output logic [IDX_W-1:0] inv_index
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_MAX + 2);

  btb_state_e    state;
  logic [CW-1:0] count;
  btb_upd_t      head;
  logic [HW-1:0] hold;
  logic          elig0, elig1, dup;
  logic          push0, push1, pop;
  logic          conflict, non_empty;
  logic          unused_fetch_hi;

  // Upper fetch PC bits do not select a set.
  assign unused_fetch_hi = ^fetch_pc[31:IDX_W];

  // A not-taken direct branch leaves the BTB unchanged, so it is not queued.
  assign elig0 = in0_valid && (in0_taken || in0_type != BTB_DIRECT);
  assign elig1 = in1_valid && (in1_taken || in1_type != BTB_DIRECT);
  assign dup   = elig0 && elig1 && (in0_pc == in1_pc);

  // Two free entries are required so a full pair can always be taken.
  assign in_ready = (state == ST_RUN) && (count <= CW'(DEPTH - 2));
  assign push0    = in_ready && !inv_req && elig0 && !dup;
  assign push1    = in_ready && !inv_req && elig1;

  assign non_empty = (count != '0);
  assign conflict  = fetch_valid && (fetch_pc[IDX_W-1:0] == head.pc[IDX_W-1:0]);
  assign pop       = (state == ST_RUN) && !inv_req && non_empty &&
                     (!conflict || hold == HW'(HOLD_MAX));
  assign inv_busy  = (state == ST_INV);

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (inv_req),
    .push0      (push0),
    .push0_data ({in0_pc, in0_target, in0_type}),
    .push1      (push1),
    .push1_data ({in1_pc, in1_target, in1_type}),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  // Counts consecutive deferrals of the current head; cleared on pop or invalidate.
  always_ff @(posedge clk) begin
    if (!resetn || state != ST_RUN || inv_req || pop) begin
      hold <= '0;
    end else if (non_empty) begin
      hold <= hold + HW'(1);
    end
  end

  // RUN/INV sequencer; inv_index doubles as the walk counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_RUN;
      inv_en    <= 1'b0;
      inv_index <= '0;
    end else if (inv_req) begin
      state     <= ST_INV;
      inv_en    <= 1'b1;
      inv_index <= '0;
    end else if (state == ST_INV) begin
      if (inv_index == '1) begin
        state  <= ST_RUN;
        inv_en <= 1'b0;
      end else begin
        inv_en    <= 1'b1;
        inv_index <= inv_index + IDX_W'(1);
      end
    end else begin
      inv_en <= 1'b0;
    end
  end

  // BTB write port: strobe follows a pop, data holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      upd_en   <= 1'b0;
      upd_pc   <= '0;
      upd_bta  <= '0;
      upd_type <= '0;
    end else begin
      upd_en <= pop;
      if (pop) begin
        upd_pc   <= head.pc;
        upd_bta  <= head.bta;
        upd_type <= head.btype;
      end
    end
  end

endmodule
